gb_out_stream_cmp: RTL

Output-side comparator for the Gaussian-blur equivalence harness. It consumes the two 8-bit AXI-Stream pixel outputs, lane A from the ILA model and lane B from the HLS design, and drives their TREADY. Each lane is buffered independently so the two producers may run with arbitrary relative skew. Pixels are compared pairwise in order, and the block reports a frame pass/fail with the first mismatching index and values.

---
 rtl/gb_cmp_pkg.sv | 23 ++
 rtl/gb_cmp_fifo.sv | 58 +++++
 rtl/gb_out_stream_cmp.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/gb_cmp_pkg.sv
// =============================================================================
// Module  : gb_cmp_pkg
// Purpose : Shared state encoding and default sizing for the blur output comparator.
// Rev     : 1.0 - initial release
// =============================================================================
`default_nettype none

package gb_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_FRAME_PIXELS = 1024;
    localparam int DEF_CNT_W        = 20;

endpackage

`default_nettype wire

// File: rtl/gb_cmp_fifo.sv
// =============================================================================
// Module  : gb_cmp_fifo
// Purpose : Per-lane synchronous FIFO with flush; extra pointer bit separates full/empty.
// Rev     : 1.0 - initial release
// =============================================================================
`default_nettype none

module gb_cmp_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/gb_out_stream_cmp.sv
// =============================================================================
// Module  : gb_out_stream_cmp
// Purpose : Buffers the ILA and HLS pixel streams and compares them pairwise per frame.
// Rev     : 1.0 - initial release
// =============================================================================
`default_nettype none

module gb_out_stream_cmp
    import gb_cmp_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a_tdata,
    input  logic              a_tvalid,
    output logic              a_tready,
    input  logic [DATA_W-1:0] b_tdata,
    input  logic              b_tvalid,
    output logic              b_tready,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [CNT_W-1:0]  pix_cnt,
    output logic [CNT_W-1:0]  first_mis_idx,
    output logic [DATA_W-1:0] first_mis_a,
    output logic [DATA_W-1:0] first_mis_b
);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_PIXELS - 1);

    state_t            state;
    state_t            state_nxt;
    logic              clear;
    logic              cmp_fire;
    logic              a_push;
    logic              b_push;
    logic              a_full;
    logic              b_full;
    logic              a_empty;
    logic              b_empty;
    logic [DATA_W-1:0] a_head;
    logic [DATA_W-1:0] b_head;
    logic [CNT_W-1:0]  a_acc_cnt;
    logic [CNT_W-1:0]  b_acc_cnt;

    // Ready is a function of buffer room and frame quota only, never of valid.
    assign a_tready = (state == RUN) && !a_full && (a_acc_cnt < FRAME_CNT);
    assign b_tready = (state == RUN) && !b_full && (b_acc_cnt < FRAME_CNT);
    assign a_push   = a_tvalid && a_tready;
    assign b_push   = b_tvalid && b_tready;
    assign cmp_fire = (state == RUN) && !a_empty && !b_empty;
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    gb_cmp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo_a (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .flush (clear),
        .push  (a_push),
        .pop   (cmp_fire),
        .din   (a_tdata),
        .dout  (a_head),
        .full  (a_full),
        .empty (a_empty)
    );

    gb_cmp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo_b (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .flush (clear),
        .push  (b_push),
        .pop   (cmp_fire),
        .din   (b_tdata),
        .dout  (b_head),
        .full  (b_full),
        .empty (b_empty)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cmp_fire && (pix_cnt == LAST_IDX)) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_acc_cnt     <= '0;
            b_acc_cnt     <= '0;
            pix_cnt       <= '0;
            mismatch      <= 1'b0;
            first_mis_idx <= '0;
            first_mis_a   <= '0;
            first_mis_b   <= '0;
        end else if (clear) begin
            a_acc_cnt     <= '0;
            b_acc_cnt     <= '0;
            pix_cnt       <= '0;
            mismatch      <= 1'b0;
            first_mis_idx <= '0;
            first_mis_a   <= '0;
            first_mis_b   <= '0;
        end else begin
            if (a_push) a_acc_cnt <= a_acc_cnt + CNT_W'(1);
            if (b_push) b_acc_cnt <= b_acc_cnt + CNT_W'(1);
            if (cmp_fire) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
                // Only the first differing pair is captured; later ones just keep the flag set.
                if ((a_head != b_head) && !mismatch) begin
                    mismatch      <= 1'b1;
                    first_mis_idx <= pix_cnt;
                    first_mis_a   <= a_head;
                    first_mis_b   <= b_head;
                end
            end
        end
    end

endmodule

`default_nettype wire
